tx_mod: RTL and testbench
=========================

# tx_mod

UART transmitter that serialises one NB_DATA-bit word per request onto the `o_tx` line: start bit, data LSB first, optional parity, then NB_STOP stop bits. It pairs with `rx_mod`, shares the 16x oversampling tick from `baud_gen`, and receives its data and start request from the `interface` block. `o_tx_done_tick` returns to `interface` as the completion handshake.

## Interface
- `NB_DATA`, 8, data bits per frame (5..9).
- `NB_STOP`, 1, stop bits (1 or 2).
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd.
- `i_clk`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `i_s_tick`  in  1  one-clock pulse at 16x baud rate from `baud_gen`.
- `i_tx_start`  in  1  request to send `i_din`; sampled only in IDLE.
- `i_din`  in  NB_DATA  word to transmit; captured on the accepting edge.
- `o_tx`  out  1  serial line, registered, idle high.
- `o_tx_done_tick`  out  1  registered one-clock pulse on frame completion.
- `o_tx_busy`  out  1  high from the accept edge until the frame ends.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Internal registers:
  - `s_cnt`: 4-bit tick counter, 0..15.
  - `n_cnt`: bit counter, clog2(NB_DATA) bits.
  - `b_reg`: NB_DATA shift register.
  - `p_reg`: parity accumulator.
  - `stp_cnt`: stop-bit counter.
- IDLE:
  - `o_tx`=1, `o_tx_busy`=0.
  - On `i_tx_start`=1: load `b_reg`←`i_din` and compute `p_reg` from it (even: XOR of bits; odd: inverted XOR). Clear `s_cnt` and `n_cnt`, go to START.
- START: `o_tx`=0. On each `i_s_tick`, increment `s_cnt`. On the tick where `s_cnt`=15, set `s_cnt`←0 and go to DATA.
- DATA:
  - `o_tx`=`b_reg[0]`.
  - On the tick where `s_cnt`=15, shift `b_reg` right and increment `n_cnt`.
  - After bit NB_DATA-1, go to PAR (if PARITY≠0) or STOP, with `s_cnt` and `stp_cnt` cleared.
- PAR: `o_tx`=`p_reg`. Holds for 16 ticks, then goes to STOP.
- STOP:
  - `o_tx`=1.
  - After 16 ticks, increment `stp_cnt`. When `stp_cnt` reaches NB_STOP, go to IDLE and assert `o_tx_done_tick` for exactly the next clock cycle.
- `i_tx_start` outside IDLE is ignored; no queuing.
- `i_din` changes after the accept edge do not affect the frame in flight.
- `i_s_tick` absent: all counters hold and `o_tx` holds its level indefinitely.
- PARITY values other than 0/1/2 behave as 0.

## Timing
- Reset (`i_reset`=0), applied immediately and asynchronously: `o_tx`=1, `o_tx_done_tick`=0, `o_tx_busy`=0, state IDLE, all counters 0.
- Reset mid-frame aborts the frame; the line returns high with no done pulse.
- Acceptance latency:
  - `i_tx_start` high at rising edge k in IDLE.
  - From edge k onward: `o_tx`=0 and `o_tx_busy`=1 (output registered, one cycle after request presented).
- Each bit lasts exactly 16 `i_s_tick` pulses.
- Bit boundaries occur on the clock edge that samples the 16th tick of the bit.
- Ticks arriving before the accept edge do not count.
- Frame length: 16×(1+NB_DATA+(PARITY≠0)+NB_STOP) ticks.
- Completion:
  - The edge sampling the final stop tick moves the state to IDLE, drops `o_tx_busy`, and raises `o_tx_done_tick`.
  - `o_tx_done_tick` falls at the following edge.
- Back-to-back: `i_tx_start` asserted during the `o_tx_done_tick` cycle is accepted. The next start bit begins one clock after the previous stop bit ends, with no extra idle bit time.
- `i_s_tick` coinciding with the accept edge is not counted.

## Test plan
- 8N1, `i_din`=0x5A, tick every 4 clocks -> `o_tx` sequence 0,0,1,0,1,1,0,1,0,1, each level held 64 clocks; one `o_tx_done_tick` pulse; `o_tx_busy` high for 640 clocks.
- PARITY=1 with 0x07, and PARITY=2 with 0x07 -> parity bit 1 (even) and 0 (odd), placed after bit 7 and before the stop bit.
- Back-to-back: 0xFF then 0x00, start held high through the done pulse -> second start bit's falling edge exactly 1 clock after the first frame's stop bit ends; two done pulses.
- `i_tx_start` pulsed with 0x33 during DATA of a 0xA5 frame -> 0xA5 frame unaffected; 0x33 never transmitted; single done pulse.
- `i_reset`=0 asynchronously during bit 3 of 0x0F -> `o_tx`=1 before the next clock edge; no done pulse. After release, a new frame of 0x81 is transmitted correctly.
- NB_STOP=2, `i_s_tick` stalled for 100 clocks mid-stop -> `o_tx` stays 1; the frame completes after 32 total stop ticks; done pulse follows.

Source files
------------

// File: rtl/tx_mod.sv
// tx_mod: UART transmitter, one NB_DATA-bit word per request.
// Frame: start bit, data LSB first, optional parity, NB_STOP stop bits.
// Each bit lasts 16 i_s_tick pulses (16x oversampling tick).
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_s_tick       one-clock pulse at 16x baud
//   i_tx_start     send request, honoured only in IDLE
//   i_din          word to send, captured on the accept edge
//   o_tx           registered serial line, idle high
//   o_tx_done_tick registered one-clock pulse after the last stop bit
//   o_tx_busy      high from accept edge until frame end
module tx_mod #(
    parameter int NB_DATA = 8,
    parameter int NB_STOP = 1,
    parameter int PARITY  = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_din,
    output logic               o_tx,
    output logic               o_tx_done_tick,
    output logic               o_tx_busy
);

    localparam int NB_N = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam bit HAS_PAR = (PARITY == 1) || (PARITY == 2);
    localparam logic [NB_N-1:0] LAST_N = NB_N'(NB_DATA - 1);
    localparam logic [1:0] LAST_STP = 2'(NB_STOP - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [3:0]        r_s_cnt;
    logic [3:0]        w_s_cnt_nx;
    logic [NB_N-1:0]   r_n_cnt;
    logic [NB_N-1:0]   w_n_cnt_nx;
    logic [NB_DATA-1:0] r_b;
    logic [NB_DATA-1:0] w_b_nx;
    logic              r_p;
    logic              w_p_nx;
    logic [1:0]        r_stp;
    logic [1:0]        w_stp_nx;
    logic              r_tx;
    logic              w_tx_nx;
    logic              r_done;
    logic              w_done_nx;
    logic              w_last_tick;

    assign w_last_tick = i_s_tick && (r_s_cnt == 4'd15);

    always_comb begin
        w_state_nx = r_state;
        w_s_cnt_nx = r_s_cnt;
        w_n_cnt_nx = r_n_cnt;
        w_b_nx     = r_b;
        w_p_nx     = r_p;
        w_stp_nx   = r_stp;
        w_done_nx  = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Ticks in IDLE, including one on the accept edge, are ignored.
                if (i_tx_start) begin
                    w_b_nx     = i_din;
                    w_p_nx     = (PARITY == 2) ? ~^i_din : ^i_din;
                    w_s_cnt_nx = 4'd0;
                    w_n_cnt_nx = '0;
                    w_stp_nx   = 2'd0;
                    w_state_nx = START;
                end
            end
            START: begin
                if (w_last_tick) begin
                    w_s_cnt_nx = 4'd0;
                    w_state_nx = DATA;
                end else if (i_s_tick) begin
                    w_s_cnt_nx = r_s_cnt + 4'd1;
                end
            end
            DATA: begin
                if (w_last_tick) begin
                    w_s_cnt_nx = 4'd0;
                    w_b_nx     = r_b >> 1;
                    if (r_n_cnt == LAST_N) begin
                        w_stp_nx   = 2'd0;
                        w_state_nx = HAS_PAR ? PAR : STOP;
                    end else begin
                        w_n_cnt_nx = r_n_cnt + 1'b1;
                    end
                end else if (i_s_tick) begin
                    w_s_cnt_nx = r_s_cnt + 4'd1;
                end
            end
            PAR: begin
                if (w_last_tick) begin
                    w_s_cnt_nx = 4'd0;
                    w_state_nx = STOP;
                end else if (i_s_tick) begin
                    w_s_cnt_nx = r_s_cnt + 4'd1;
                end
            end
            STOP: begin
                if (w_last_tick) begin
                    w_s_cnt_nx = 4'd0;
                    if (r_stp == LAST_STP) begin
                        w_state_nx = IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_stp_nx = r_stp + 2'd1;
                    end
                end else if (i_s_tick) begin
                    w_s_cnt_nx = r_s_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Line level is derived from the next state so o_tx can be registered
    // and still change on the same edge as the state.
    always_comb begin
        w_tx_nx = 1'b1;
        unique case (w_state_nx)
            IDLE:    w_tx_nx = 1'b1;
            START:   w_tx_nx = 1'b0;
            DATA:    w_tx_nx = w_b_nx[0];
            PAR:     w_tx_nx = w_p_nx;
            STOP:    w_tx_nx = 1'b1;
            default: w_tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
            r_s_cnt <= 4'd0;
            r_n_cnt <= '0;
            r_b     <= '0;
            r_p     <= 1'b0;
            r_stp   <= 2'd0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_s_cnt <= w_s_cnt_nx;
            r_n_cnt <= w_n_cnt_nx;
            r_b     <= w_b_nx;
            r_p     <= w_p_nx;
            r_stp   <= w_stp_nx;
            r_tx    <= w_tx_nx;
            r_done  <= w_done_nx;
        end
    end

    assign o_tx           = r_tx;
    assign o_tx_done_tick = r_done;
    assign o_tx_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_tx_mod.sv
// tb_tx_mod: scoreboard bench for tx_mod.
// Expected line levels are queued per frame and checked by a monitor.
module tb_tx_mod;

    typedef struct {
        string lv;
        bit    tim;
        bit    gap;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       tick_en;
    logic [3:0] st;
    logic [7:0] din;
    logic [1:0] sel;
    logic [3:0] txv;
    logic [3:0] bsv;
    logic [3:0] dnv;
    logic       w_tx;
    logic       w_busy;
    logic       w_done;
    logic       abort;

    int   n_chk;
    int   n_fail;
    int   mstate;
    int   cyc;
    int   done_cyc;
    int   dcnt;
    int   tph;
    exp_t q[$];

    tx_mod u_n1 (
        .i_clk(clk), .i_reset(rst_n), .i_s_tick(tick),
        .i_tx_start(st[0]), .i_din(din), .o_tx(txv[0]),
        .o_tx_done_tick(dnv[0]), .o_tx_busy(bsv[0])
    );
    tx_mod #(.PARITY(1)) u_pe (
        .i_clk(clk), .i_reset(rst_n), .i_s_tick(tick),
        .i_tx_start(st[1]), .i_din(din), .o_tx(txv[1]),
        .o_tx_done_tick(dnv[1]), .o_tx_busy(bsv[1])
    );
    tx_mod #(.PARITY(2)) u_po (
        .i_clk(clk), .i_reset(rst_n), .i_s_tick(tick),
        .i_tx_start(st[2]), .i_din(din), .o_tx(txv[2]),
        .o_tx_done_tick(dnv[2]), .o_tx_busy(bsv[2])
    );
    tx_mod #(.NB_STOP(2)) u_s2 (
        .i_clk(clk), .i_reset(rst_n), .i_s_tick(tick),
        .i_tx_start(st[3]), .i_din(din), .o_tx(txv[3]),
        .o_tx_done_tick(dnv[3]), .o_tx_busy(bsv[3])
    );

    assign w_tx   = txv[sel];
    assign w_busy = bsv[sel];
    assign w_done = dnv[sel];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        tph  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                tph  = (tph + 1) % 4;
                tick = (tph == 0);
            end else begin
                tick = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not as required", nm);
    endtask

    initial begin
        done_cyc = 0;
        dcnt     = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (dnv[i] === 1'b1) dcnt++;
        end
    end

    initial begin : monitor
        exp_t cur;
        int   idx, tc, clks, fclks;
        bit   bad, bbad;
        logic eb;
        mstate = 0;
        cyc    = 0;
        idx = 0; tc = 0; clks = 0; fclks = 0; bad = 0; bbad = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (abort) begin
                mstate = 0;
            end else if (mstate == 2) begin
                chk("done_rise", {31'b0, w_done}, 1);
                chk("busy_end", {31'b0, w_busy}, 0);
                chk("tx_end", {31'b0, w_tx}, 1);
                done_cyc = cyc;
                mstate   = 3;
            end else begin
                if (mstate == 3) begin
                    chk("done_fall", {31'b0, w_done}, 0);
                    mstate = 0;
                end
                if (mstate == 0 && w_tx === 1'b0) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_frame");
                        mstate = 5;
                    end else begin
                        cur = q.pop_front();
                        if (cur.gap)
                            chk("b2b_gap", cyc - done_cyc, 1);
                        idx = 0; tc = 0; clks = 0; fclks = 0;
                        bad = 0; bbad = 0;
                        mstate = 1;
                    end
                end
                if (mstate == 1) begin
                    eb = (cur.lv[idx] == 8'h31);
                    if (w_tx !== eb) bad = 1;
                    if (w_busy !== 1'b1) bbad = 1;
                    else fclks++;
                    clks++;
                    if (tick === 1'b1) tc++;
                    if (tc == 16) begin
                        chk($sformatf("bit%0d_level", idx),
                            {31'b0, bad ? ~eb : eb}, {31'b0, eb});
                        if (cur.tim)
                            chk($sformatf("bit%0d_clocks", idx), clks, 64);
                        idx++;
                        tc = 0; clks = 0; bad = 0;
                        if (idx == cur.lv.len()) begin
                            chk("busy_in_frame", {31'b0, bbad}, 0);
                            if (cur.tim)
                                chk("busy_clocks", fclks, cur.lv.len() * 64);
                            mstate = 2;
                        end
                    end
                end
                if (mstate == 5 && w_busy === 1'b0 && w_tx === 1'b1)
                    mstate = 0;
            end
        end
    end

    task automatic push(input string lv, input bit tim, input bit gap);
        exp_t e;
        e.lv  = lv;
        e.tim = tim;
        e.gap = gap;
        q.push_back(e);
    endtask

    // Raise start so the accept edge coincides with a tick.
    task automatic raise(input int s, input logic [7:0] d);
        do begin
            @(posedge clk);
            #2;
        end while (tick !== 1'b1);
        din   = d;
        st[s] = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int s, input logic [7:0] d);
        raise(s, d);
        st[s] = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            #1;
            if (mstate == 0 && q.size() == 0 && w_busy === 1'b0) return;
        end
        fail_now("timeout_idle");
    endtask

    initial begin : stim
        bit seen;
        n_chk   = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        tick_en = 1'b1;
        st      = 4'b0;
        din     = 8'h00;
        sel     = 2'd0;
        abort   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst_tx%0d", i), {31'b0, txv[i]}, 1);
            chk($sformatf("rst_busy%0d", i), {31'b0, bsv[i]}, 0);
            chk($sformatf("rst_done%0d", i), {31'b0, dnv[i]}, 0);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        sel = 2'd0;
        push("0010110101", 1, 0);
        send(0, 8'h5A);
        chk("accept_tx", {31'b0, w_tx}, 0);
        chk("accept_busy", {31'b0, w_busy}, 1);
        wait_idle(3000);

        sel = 2'd1;
        push("01110000011", 1, 0);
        send(1, 8'h07);
        wait_idle(3000);

        sel = 2'd2;
        push("01110000001", 1, 0);
        send(2, 8'h07);
        wait_idle(3000);

        sel = 2'd0;
        push("0111111111", 1, 0);
        push("0000000001", 0, 1);
        raise(0, 8'hFF);
        din  = 8'h00;
        seen = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (w_done === 1'b1) seen = 1;
        end
        if (!seen) fail_now("timeout_b2b_done");
        @(posedge clk);
        #2;
        st[0] = 1'b0;
        wait_idle(3000);

        push("0101001011", 1, 0);
        send(0, 8'hA5);
        repeat (200) @(posedge clk);
        #2;
        din   = 8'h33;
        st[0] = 1'b1;
        @(posedge clk);
        #2;
        st[0] = 1'b0;
        wait_idle(3000);

        push("0111100001", 0, 0);
        send(0, 8'h0F);
        repeat (288) @(negedge clk);
        #2;
        rst_n = 1'b0;
        abort = 1'b1;
        #1;
        chk("abort_tx", {31'b0, w_tx}, 1);
        chk("abort_busy", {31'b0, w_busy}, 0);
        chk("abort_done", {31'b0, w_done}, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        abort = 1'b0;
        push("0100000011", 1, 0);
        send(0, 8'h81);
        wait_idle(3000);

        sel = 2'd3;
        push("00011110011", 0, 0);
        send(3, 8'h3C);
        repeat (650) @(posedge clk);
        #2;
        tick_en = 1'b0;
        repeat (100) @(posedge clk);
        #2;
        chk("stall_tx", {31'b0, w_tx}, 1);
        chk("stall_busy", {31'b0, w_busy}, 1);
        tick_en = 1'b1;
        wait_idle(3000);

        repeat (5) @(negedge clk);
        chk("queue_empty", q.size(), 0);
        chk("done_pulses", dcnt, 8);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
